// File: rtl/deser_bitslip_align.sv
// deser_bitslip_align: word alignment for ISERDES2 channels. Each channel searches for the
// training pattern with BITSLIP pulses and reports its lock, its slip count and a fail flag.
module deser_bitslip_align #(
    parameter int unsigned DESER_WIDTH = 6,
    parameter int unsigned CHANNEL_NUM = 4,
    parameter logic [DESER_WIDTH-1:0] TRAINING_PATTERN = 6'b111000,
    parameter int unsigned MATCH_NUM = 4,
    parameter int unsigned SLIP_WAIT = 3
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              i_start,
    input  logic [CHANNEL_NUM*DESER_WIDTH-1:0] iv_data,
    output logic [CHANNEL_NUM-1:0]            ov_bitslip,
    output logic [CHANNEL_NUM-1:0]            ov_lock,
    output logic [CHANNEL_NUM*4-1:0]          ov_slip_cnt,
    output logic                              o_align_done,
    output logic                              o_align_fail
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_COMPARE, ST_SLIP, ST_WAIT, ST_LOCKED, ST_FAIL
    } state_t;

    localparam logic [3:0] MATCH_LAST = 4'(MATCH_NUM - 1);
    localparam logic [3:0] SLIP_LIMIT = 4'(DESER_WIDTH);
    localparam logic [3:0] WAIT_LAST  = 4'(SLIP_WAIT - 1);

    logic [CHANNEL_NUM-1:0] fail;

    for (genvar c = 0; c < CHANNEL_NUM; c++) begin : g_ch
        state_t                 state, state_nxt;
        logic [3:0]             match_cnt, match_nxt;
        logic [3:0]             slip_cnt, slip_nxt;
        logic [3:0]             wait_cnt, wait_nxt;
        logic [DESER_WIDTH-1:0] word;

        assign word = iv_data[c*DESER_WIDTH +: DESER_WIDTH];

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                state     <= ST_IDLE;
                match_cnt <= '0;
                slip_cnt  <= '0;
                wait_cnt  <= '0;
            end else begin
                state     <= state_nxt;
                match_cnt <= match_nxt;
                slip_cnt  <= slip_nxt;
                wait_cnt  <= wait_nxt;
            end
        end

        always_comb begin
            state_nxt = state;
            match_nxt = match_cnt;
            slip_nxt  = slip_cnt;
            wait_nxt  = wait_cnt;
            if (i_start) begin
                state_nxt = ST_COMPARE;
                match_nxt = '0;
                slip_nxt  = '0;
                wait_nxt  = '0;
            end else begin
                case (state)
                    ST_COMPARE: begin
                        if (word == TRAINING_PATTERN) begin
                            match_nxt = match_cnt + 4'd1;
                            if (match_cnt == MATCH_LAST) state_nxt = ST_LOCKED;
                        end else begin
                            match_nxt = '0;
                            // every rotation tried: the ISERDES is back where it started
                            state_nxt = (slip_cnt >= SLIP_LIMIT) ? ST_FAIL : ST_SLIP;
                        end
                    end
                    ST_SLIP: begin
                        slip_nxt  = slip_cnt + 4'd1;
                        wait_nxt  = '0;
                        state_nxt = ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (wait_cnt == WAIT_LAST) begin
                            wait_nxt  = '0;
                            state_nxt = ST_COMPARE;
                        end else begin
                            wait_nxt = wait_cnt + 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        assign ov_bitslip[c]        = (state == ST_SLIP);
        assign ov_lock[c]           = (state == ST_LOCKED);
        assign fail[c]              = (state == ST_FAIL);
        assign ov_slip_cnt[c*4 +: 4] = slip_cnt;
    end

    assign o_align_done = &ov_lock;
    assign o_align_fail = |fail;
endmodule

// File: tb/tb_deser_bitslip_align.sv
// Bench for deser_bitslip_align: an ISERDES rotation model drives the channels and a
// timing model derived from slip/settle/match counts predicts every output each cycle.
module tb_deser_bitslip_align;
    localparam int unsigned W     = 6;
    localparam int unsigned CH    = 4;
    localparam int unsigned MN    = 4;
    localparam int unsigned SW    = 3;
    localparam int unsigned NEVER = 6;
    localparam logic [5:0]  P     = 6'b111000;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             i_start;
    logic [CH*W-1:0]  iv_data;
    logic [CH-1:0]    ov_bitslip;
    logic [CH-1:0]    ov_lock;
    logic [CH*4-1:0]  ov_slip_cnt;
    logic             o_align_done;
    logic             o_align_fail;

    always #5 clk = ~clk;

    deser_bitslip_align #(
        .DESER_WIDTH(W), .CHANNEL_NUM(CH), .TRAINING_PATTERN(P),
        .MATCH_NUM(MN), .SLIP_WAIT(SW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .iv_data(iv_data),
        .ov_bitslip(ov_bitslip), .ov_lock(ov_lock), .ov_slip_cnt(ov_slip_cnt),
        .o_align_done(o_align_done), .o_align_fail(o_align_fail)
    );

    int          checks   = 0;
    int          failures = 0;
    int unsigned pos [CH];
    int unsigned junk[CH];
    int unsigned kreq[CH];
    logic        ovr_en  [CH];
    logic [5:0]  ovr_word[CH];

    typedef struct packed {
        logic [3:0][2:0] k;
        logic [15:0]     slips;
        logic [3:0]      lock;
        logic            done;
        logic            fail;
    } vec_t;
    vec_t tbl[5];

    function automatic logic [5:0] rotl(input logic [5:0] w, input int unsigned n);
        logic [5:0] r;
        r = w;
        for (int unsigned i = 0; i < n % W; i++) r = {r[4:0], r[5]};
        return r;
    endfunction

    function automatic logic [31:0] act();
        return 32'({ov_bitslip, ov_lock, ov_slip_cnt, o_align_done, o_align_fail});
    endfunction

    // Edge e counts clocks after the start edge: pulses every SW+2 edges from edge 1,
    // the count steps one edge after each pulse, lock MN edges after the last settle.
    function automatic logic [31:0] expect_at(input int unsigned e);
        logic [3:0]  bs, lk;
        logic [15:0] sc;
        logic        fl;
        int unsigned n, s;
        bs = '0; lk = '0; sc = '0; fl = 1'b0;
        for (int c = 0; c < CH; c++) begin
            n = (kreq[c] >= NEVER) ? W : kreq[c];
            if (e >= 1 && (e - 1) % (SW + 2) == 0 && (e - 1) / (SW + 2) < n) bs[c] = 1'b1;
            if (e >= 2) begin
                s = (e - 2) / (SW + 2) + 1;
                sc[c*4 +: 4] = 4'((s < n) ? s : n);
            end
            if (kreq[c] < NEVER && e >= (SW + 2) * kreq[c] + MN) lk[c] = 1'b1;
            if (kreq[c] >= NEVER && e >= (SW + 2) * W + 1) fl = 1'b1;
        end
        return 32'({bs, lk, sc, &lk, fl});
    endfunction

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, a, x);
        end
    endtask

    // ISERDES model: a BITSLIP rotates the word one bit; two cycles of junk follow.
    task automatic model_update();
        for (int c = 0; c < CH; c++) begin
            if (junk[c] > 0) junk[c]--;
            if (ov_bitslip[c]) begin
                pos[c]++;
                junk[c] = 2;
            end
        end
    endtask

    task automatic drive();
        for (int c = 0; c < CH; c++) begin
            logic [5:0] w;
            if (ovr_en[c])              w = ovr_word[c];
            else if (junk[c] > 0)       w = 6'($urandom);
            else if (kreq[c] >= NEVER)  w = rotl(6'b101010, pos[c]);
            else                        w = rotl(P, (W - kreq[c] + pos[c]) % W);
            iv_data[c*W +: W] = w;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_update();
        drive();
    endtask

    task automatic setup(input int unsigned k0, k1, k2, k3);
        kreq = '{k0, k1, k2, k3};
        for (int c = 0; c < CH; c++) begin
            pos[c] = 0; junk[c] = 0; ovr_en[c] = 1'b0; ovr_word[c] = P;
        end
        drive();
    endtask

    task automatic run_align(input int unsigned k0, k1, k2, k3, input string tag,
                             output int done_e, output int lock2_e);
        done_e = -1; lock2_e = -1;
        setup(k0, k1, k2, k3);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        check($sformatf("%s e0", tag), act(), expect_at(0));
        for (int unsigned e = 1; e <= 40; e++) begin
            step();
            check($sformatf("%s e%0d", tag, e), act(), expect_at(e));
            if (done_e < 0 && o_align_done) done_e = int'(e);
            if (lock2_e < 0 && ov_lock[2])  lock2_e = int'(e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int de, le, pulses;
        tbl[0] = '{k: {3'd0, 3'd0, 3'd0, 3'd0}, slips: {4'd0, 4'd0, 4'd0, 4'd0},
                   lock: 4'b1111, done: 1'b1, fail: 1'b0};
        tbl[1] = '{k: {3'd2, 3'd5, 3'd1, 3'd0}, slips: {4'd2, 4'd5, 4'd1, 4'd0},
                   lock: 4'b1111, done: 1'b1, fail: 1'b0};
        tbl[2] = '{k: {3'd3, 3'd3, 3'd3, 3'd3}, slips: {4'd3, 4'd3, 4'd3, 4'd3},
                   lock: 4'b1111, done: 1'b1, fail: 1'b0};
        tbl[3] = '{k: {3'd4, 3'd2, 3'd0, 3'd6}, slips: {4'd4, 4'd2, 4'd0, 4'd6},
                   lock: 4'b1110, done: 1'b0, fail: 1'b1};
        tbl[4] = '{k: {3'd1, 3'd6, 3'd6, 3'd5}, slips: {4'd1, 4'd6, 4'd6, 4'd5},
                   lock: 4'b1001, done: 1'b0, fail: 1'b1};

        reset_n = 1'b0;
        i_start = 1'b0;
        setup(0, 0, 0, 0);
        repeat (3) step();
        check("reset outputs", act(), 32'h0);
        reset_n = 1'b1;
        repeat (3) step();
        check("idle holds", act(), 32'h0);

        for (int r = 0; r < 5; r++) begin
            run_align(tbl[r].k[0], tbl[r].k[1], tbl[r].k[2], tbl[r].k[3],
                      $sformatf("row%0d", r), de, le);
            check($sformatf("row%0d slip_cnt", r), 32'(ov_slip_cnt), 32'(tbl[r].slips));
            check($sformatf("row%0d lock", r), 32'(ov_lock), 32'(tbl[r].lock));
            check($sformatf("row%0d done/fail", r), 32'({o_align_done, o_align_fail}),
                  32'({tbl[r].done, tbl[r].fail}));
            if (r == 1) begin
                check("row1 ch2 lock edge", 32'(le), 32'd29);
                check("row1 done edge", 32'(de), 32'd29);
            end
            if (r == 3) begin
                for (int i = 0; i < 100; i++) begin
                    step();
                    check($sformatf("fail hold %0d", i), act(),
                          32'({4'b0, tbl[3].lock, tbl[3].slips, 1'b0, 1'b1}));
                end
            end
        end

        // match twice, one mismatch, then steady pattern on channel 0
        setup(0, 0, 0, 0);
        ovr_en[0] = 1'b1;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        pulses = 0;
        for (int e = 1; e <= 12; e++) begin
            ovr_word[0] = (e == 3) ? 6'b000111 : P;
            drive();
            step();
            if (ov_bitslip[0]) pulses++;
            if (e == 3)  check("mm slip pulse", 32'(ov_bitslip[0]), 32'd1);
            if (e == 10) check("mm no early lock", 32'(ov_lock[0]), 32'd0);
            if (e == 11) check("mm lock", 32'(ov_lock[0]), 32'd1);
        end
        check("mm slip_cnt", 32'(ov_slip_cnt[3:0]), 32'd1);
        check("mm pulse count", 32'(pulses), 32'd1);

        // restart while waiting after a slip
        setup(1, 1, 1, 1);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        step();
        check("restart pre pulse", 32'(ov_bitslip), 32'hF);
        step();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        check("restart cleared", act(), 32'h0);
        repeat (3) step();
        check("restart no early lock", 32'(ov_lock), 32'h0);
        step();
        check("restart relock", act(), 32'({4'b0, 4'hF, 16'h0, 1'b1, 1'b0}));

        // reset asserted with bitslip high, start asserted on the same edge
        setup(1, 1, 1, 1);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        step();
        check("reset pre pulse", 32'(ov_bitslip), 32'hF);
        reset_n = 1'b0;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        check("reset mid slip", act(), 32'h0);
        reset_n = 1'b1;
        repeat (8) step();
        check("reset beats start", act(), 32'h0);
        run_align(2, 0, 1, 0, "post reset", de, le);

        for (int it = 0; it < 20; it++) begin
            repeat ($urandom_range(0, 3)) step();
            run_align($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
                      $urandom_range(0, 6), $sformatf("rand%0d", it), de, le);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
